i2c_cfg_seq: RTL and testbench
==============================

Name: i2c_cfg_seq

Overview:
- Sequences a table of codec register writes through the I2C master transaction engine, one 3-byte write per entry: device address, then a 16-bit word.
- Owns the engine's start/data handshake, handles NACK with bounded retry, and raises a sticky status when the table completes or fails.
- Sits between top-level control (board key or power-on pulse) and the I2C master, so no upstream logic drives the engine directly.

Parameters:
- NUM_REGS, 10, number of table entries issued (1..16).
- DEV_ADDR, 8'h34, 8-bit write address byte (7-bit 0x1A, R/W=0).
- MAX_RETRY, 3, attempts per entry before failing (1..7).
- GAP_CYCLES, 16'd500, idle clk_50 cycles between consecutive transactions (>=1).

Ports:
- clk_50  in  1  50 MHz system clock
- reset  in  1  synchronous active-high reset
- go  in  1  one-cycle pulse; starts or restarts the sequence
- i2c_start  out  1  one-cycle pulse to the I2C engine
- i2c_dev  out  8  address byte for the current transaction
- i2c_word  out  16  {reg_addr[6:0], reg_data[8:0]} for the current entry
- i2c_done  in  1  one-cycle pulse when the engine finishes a transaction
- i2c_nack  in  1  sampled only with i2c_done; 1 means the slave NACKed
- busy  out  1  high from the go acceptance cycle until DONE/FAIL
- cfg_done  out  1  sticky; entire table written
- cfg_fail  out  1  sticky; some entry exhausted its retries
- index  out  4  current entry (debug)

Behaviour:
- Clock and reset: one clock, clk_50; reset is synchronous, active-high.
- Reset values: state=IDLE, i2c_start=0, i2c_dev=DEV_ADDR, i2c_word=0, busy=0, cfg_done=0, cfg_fail=0, index=0, retry count=0, gap counter=0.
- IDLE: on go, go to LOAD with index=0 and retry=0; busy rises the same cycle go is sampled.
- LOAD (1 cycle): register i2c_word from the table at index, then go to ISSUE.
- ISSUE (1 cycle): i2c_start=1, then go to WAIT. i2c_word and i2c_dev stay stable from LOAD until i2c_done.
- WAIT: hold until i2c_done.
  - On ACK (i2c_nack=0): retry=0. If index==NUM_REGS-1, go to DONE; otherwise index+1 and go to GAP.
  - On NACK: retry+1. If the new retry==MAX_RETRY, go to FAIL; otherwise go to GAP with index unchanged (the entry is re-issued).
- GAP: count GAP_CYCLES cycles, then go to LOAD. Leaving GAP the cycle the count reaches GAP_CYCLES-1 gives exactly GAP_CYCLES cycles in GAP.
- DONE: cfg_done=1 and busy=0. FAIL: cfg_fail=1, busy=0, index holds the failing entry.
- Latency: go to the first i2c_start is exactly 2 cycles (LOAD, ISSUE). i2c_done to the next i2c_start is GAP_CYCLES+2 cycles.
- go while busy is ignored.
- go in DONE or FAIL clears cfg_done/cfg_fail, resets index and retry, and restarts exactly like go in IDLE.
- i2c_done outside WAIT is ignored; this includes a done arriving in the same cycle as i2c_start.
- Simultaneous go and i2c_done in WAIT: go is ignored and i2c_done is processed.
- Reset mid-transaction: the sequencer returns to IDLE immediately. The I2C engine shares the reset and is not waited on.
- Width rules:
  - index is 4 bits and never exceeds NUM_REGS-1; no wrap.
  - retry is 3 bits.
  - gap counter is 16 bits.
- Default table (entries 0..9), given as {reg, data}:
  - {0x0F,0x000} reset
  - {0x06,0x000} power
  - {0x00,0x017} left line-in
  - {0x01,0x017} right line-in
  - {0x02,0x079} left HP
  - {0x03,0x079} right HP
  - {0x04,0x012} analog path
  - {0x05,0x000} digital path
  - {0x07,0x001} format
  - {0x09,0x001} active
- Word packing: i2c_word = {reg[6:0], data[8:0]}; entry 0 therefore packs to 16'h1E00.

Decomposition:
- Shared package i2c_cfg_pkg holds:
  - state encoding constants: IDLE, LOAD, ISSUE, WAIT, GAP, DONE, FAIL (3 bits);
  - codec register address constants;
  - the default DEV_ADDR value.
- One sub-module, i2c_cfg_rom: combinational 4-bit index to 16-bit word lookup holding the table above. Indices >= NUM_REGS return 16'h0000.

Test Plan:
- All ACK (engine model returns done/ack 100 cycles after each start), NUM_REGS=10, GAP_CYCLES=4 -> 10 start pulses with words 1E00, 0C00, 0017, 0217, 0479, 0679, 0812, 0A00, 0E01, 1201 in order; cfg_done=1, busy=0; 4 cycles between each done and the next LOAD.
- Entry 3 NACKs twice then ACKs, MAX_RETRY=3 -> word 0217 issued 3 times, index stays 3, then the sequence completes with cfg_done=1.
- Entry 5 NACKs every time, MAX_RETRY=3 -> 3 starts with word 0679, then cfg_fail=1, cfg_done=0, index=5, busy=0; no further starts.
- go pulsed repeatedly while in WAIT, plus go coincident with i2c_done -> no extra start pulses and the done is processed; then go after DONE -> flags clear and the first start follows exactly 2 cycles later.
- reset asserted for 1 cycle in WAIT at entry 4 -> next cycle all outputs at reset values; a later go restarts from entry 0.
- Stray i2c_done while IDLE or in GAP -> no state change and no flag change.

Source files
------------

// File: rtl/i2c_cfg_pkg.sv
// rtl/i2c_cfg_pkg.sv - shared state encoding, codec register map and word packing
package i2c_cfg_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_GAP   = 3'd4,
    S_DONE  = 3'd5,
    S_FAIL  = 3'd6
  } state_e;

  localparam logic [7:0] DEV_ADDR_DEFAULT = 8'h34;

  localparam logic [6:0] REG_LLINE  = 7'h00;
  localparam logic [6:0] REG_RLINE  = 7'h01;
  localparam logic [6:0] REG_LHP    = 7'h02;
  localparam logic [6:0] REG_RHP    = 7'h03;
  localparam logic [6:0] REG_APATH  = 7'h04;
  localparam logic [6:0] REG_DPATH  = 7'h05;
  localparam logic [6:0] REG_POWER  = 7'h06;
  localparam logic [6:0] REG_FORMAT = 7'h07;
  localparam logic [6:0] REG_ACTIVE = 7'h09;
  localparam logic [6:0] REG_RESET  = 7'h0F;

  function automatic logic [15:0] pack_word(input logic [6:0] reg_addr, input logic [8:0] reg_data);
    return {reg_addr, reg_data};
  endfunction

endpackage

// File: rtl/i2c_cfg_rom.sv
// rtl/i2c_cfg_rom.sv - combinational codec init table, index to packed 16-bit word
module i2c_cfg_rom
  import i2c_cfg_pkg::*;
#(
  parameter int NUM_REGS = 10
) (
  input  logic [3:0]  index_i,
  output logic [15:0] word_o
);

  always_comb begin
    word_o = 16'h0000;
    // Entries beyond the configured table length read as zero.
    if (int'(index_i) < NUM_REGS) begin
      case (index_i)
        4'd0:    word_o = pack_word(REG_RESET,  9'h000);
        4'd1:    word_o = pack_word(REG_POWER,  9'h000);
        4'd2:    word_o = pack_word(REG_LLINE,  9'h017);
        4'd3:    word_o = pack_word(REG_RLINE,  9'h017);
        4'd4:    word_o = pack_word(REG_LHP,    9'h079);
        4'd5:    word_o = pack_word(REG_RHP,    9'h079);
        4'd6:    word_o = pack_word(REG_APATH,  9'h012);
        4'd7:    word_o = pack_word(REG_DPATH,  9'h000);
        4'd8:    word_o = pack_word(REG_FORMAT, 9'h001);
        4'd9:    word_o = pack_word(REG_ACTIVE, 9'h001);
        default: word_o = 16'h0000;
      endcase
    end
  end

endmodule

// File: rtl/i2c_cfg_seq.sv
// rtl/i2c_cfg_seq.sv - walks the codec init table through the I2C engine with NACK retry
module i2c_cfg_seq
  import i2c_cfg_pkg::*;
#(
  parameter int          NUM_REGS   = 10,
  parameter logic [7:0]  DEV_ADDR   = DEV_ADDR_DEFAULT,
  parameter int          MAX_RETRY  = 3,
  parameter logic [15:0] GAP_CYCLES = 16'd500
) (
  input  logic        clk_50,
  input  logic        reset,
  input  logic        go,
  output logic        i2c_start,
  output logic [7:0]  i2c_dev,
  output logic [15:0] i2c_word,
  input  logic        i2c_done,
  input  logic        i2c_nack,
  output logic        busy,
  output logic        cfg_done,
  output logic        cfg_fail,
  output logic [3:0]  index
);

  localparam logic [3:0] LAST_IDX  = 4'(NUM_REGS - 1);
  localparam logic [2:0] RETRY_LIM = 3'(MAX_RETRY);

  state_e      state_q, state_d;
  logic [3:0]  index_q, index_d;
  logic [2:0]  retry_q, retry_d;
  logic [15:0] gap_q, gap_d;
  logic [15:0] word_q, word_d;
  logic [15:0] rom_word;
  logic [2:0]  retry_inc;

  i2c_cfg_rom #(.NUM_REGS(NUM_REGS)) u_rom (
    .index_i (index_q),
    .word_o  (rom_word)
  );

  assign retry_inc = retry_q + 3'd1;

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_q <= S_IDLE;
      index_q <= 4'd0;
      retry_q <= 3'd0;
      gap_q   <= 16'd0;
      word_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      retry_q <= retry_d;
      gap_q   <= gap_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    retry_d = retry_q;
    gap_d   = gap_q;
    word_d  = word_q;
    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (go) begin
          state_d = S_LOAD;
          index_d = 4'd0;
          retry_d = 3'd0;
        end
      end
      S_LOAD: begin
        word_d  = rom_word;
        state_d = S_ISSUE;
      end
      S_ISSUE: state_d = S_WAIT;
      // Only WAIT listens to the engine; a done in any other state is dropped.
      S_WAIT: begin
        if (i2c_done) begin
          gap_d = 16'd0;
          if (!i2c_nack) begin
            retry_d = 3'd0;
            if (index_q == LAST_IDX) begin
              state_d = S_DONE;
            end else begin
              index_d = index_q + 4'd1;
              state_d = S_GAP;
            end
          end else begin
            retry_d = retry_inc;
            state_d = (retry_inc == RETRY_LIM) ? S_FAIL : S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_CYCLES - 16'd1) begin
          gap_d   = 16'd0;
          state_d = S_LOAD;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    i2c_start = (state_q == S_ISSUE);
    busy      = (state_q == S_LOAD) || (state_q == S_ISSUE) ||
                (state_q == S_WAIT) || (state_q == S_GAP);
    cfg_done  = (state_q == S_DONE);
    cfg_fail  = (state_q == S_FAIL);
    i2c_dev   = DEV_ADDR;
    i2c_word  = word_q;
    index     = index_q;
  end

endmodule

// File: tb/tb_i2c_cfg_seq.sv
// tb/tb_i2c_cfg_seq.sv - directed scoreboard bench for the codec config sequencer
module tb_i2c_cfg_seq;

  logic        clk_50 = 1'b0;
  logic        reset  = 1'b1;
  logic        go     = 1'b0;
  logic        i2c_start;
  logic [7:0]  i2c_dev;
  logic [15:0] i2c_word;
  logic        i2c_done, i2c_nack;
  logic        busy, cfg_done, cfg_fail;
  logic [3:0]  index;

  logic eng_done = 1'b0, eng_nack = 1'b0, tb_done = 1'b0, tb_nack = 1'b0;
  assign i2c_done = eng_done | tb_done;
  assign i2c_nack = eng_nack | tb_nack;

  i2c_cfg_seq #(
    .NUM_REGS   (10),
    .DEV_ADDR   (8'h34),
    .MAX_RETRY  (3),
    .GAP_CYCLES (16'd4)
  ) dut (
    .clk_50    (clk_50),
    .reset     (reset),
    .go        (go),
    .i2c_start (i2c_start),
    .i2c_dev   (i2c_dev),
    .i2c_word  (i2c_word),
    .i2c_done  (i2c_done),
    .i2c_nack  (i2c_nack),
    .busy      (busy),
    .cfg_done  (cfg_done),
    .cfg_fail  (cfg_fail),
    .index     (index)
  );

  always #10 clk_50 = ~clk_50;

  typedef struct {
    logic [15:0] word;
    logic [3:0]  idx;
  } exp_t;

  exp_t        exp_q[$];
  bit          nack_plan[$];
  logic [15:0] table_w [10] = '{16'h1E00, 16'h0C00, 16'h0017, 16'h0217, 16'h0479,
                                16'h0679, 16'h0812, 16'h0A00, 16'h0E01, 16'h1201};
  int errors = 0, checks = 0;
  int cyc = 0, eng_cnt = 0, done_cyc = 0, n_starts = 0;
  bit gap_pending = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void push_exp(input int i);
    exp_t e;
    e.word = table_w[i];
    e.idx  = 4'(i);
    exp_q.push_back(e);
  endfunction

  // One clock: engine model (done 100 cycles after start) plus start-pulse scoreboard.
  task automatic tick();
    exp_t e;
    @(negedge clk_50);
    cyc++;
    eng_done = 1'b0;
    eng_nack = 1'b0;
    if (reset) begin
      eng_cnt = 0;
    end else begin
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          eng_done    = 1'b1;
          eng_nack    = (nack_plan.size() != 0) ? nack_plan.pop_front() : 1'b0;
          done_cyc    = cyc;
          gap_pending = 1'b1;
        end
      end
      if (i2c_start) eng_cnt = 100;
    end
    if (i2c_start) begin
      n_starts++;
      check("sb_nonempty", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("start_word", 32'(i2c_word), 32'(e.word));
        check("start_index", 32'(index), 32'(e.idx));
      end
      check("start_dev", 32'(i2c_dev), 32'h34);
      if (gap_pending) begin
        check("done_to_start", 32'(cyc - done_cyc), 6);
        gap_pending = 1'b0;
      end
    end
  endtask

  task automatic pulse_go();
    gap_pending = 1'b0;
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic run_to_idle(input int max_cycles);
    for (int n = 0; n < max_cycles && busy; n++) tick();
    check("finish_in_budget", 32'(busy), 0);
  endtask

  task automatic wait_eng_done();
    for (int n = 0; n < 300 && !eng_done; n++) tick();
    check("eng_done_seen", 32'(eng_done), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_start"}, 32'(i2c_start), 0);
    check({tag, "_dev"},   32'(i2c_dev), 32'h34);
    check({tag, "_word"},  32'(i2c_word), 0);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_done"},  32'(cfg_done), 0);
    check({tag, "_fail"},  32'(cfg_fail), 0);
    check({tag, "_index"}, 32'(index), 0);
  endtask

  initial begin
    repeat (3) tick();
    check_reset_outputs("rst");
    reset = 1'b0;
    tick();

    // All entries ACKed.
    for (int i = 0; i < 10; i++) push_exp(i);
    n_starts = 0;
    pulse_go();
    check("s1_busy_rise", 32'(busy), 1);
    check("s1_no_early_start", 32'(i2c_start), 0);
    tick();
    check("s1_start_lat2", 32'(i2c_start), 1);
    run_to_idle(3000);
    check("s1_cfg_done", 32'(cfg_done), 1);
    check("s1_cfg_fail", 32'(cfg_fail), 0);
    check("s1_index", 32'(index), 9);
    check("s1_starts", 32'(n_starts), 10);
    check("s1_sb_empty", 32'(exp_q.size()), 0);

    // Entry 3 NACKs twice, then ACKs.
    nack_plan = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) push_exp(i);
    push_exp(3);
    push_exp(3);
    for (int i = 4; i < 10; i++) push_exp(i);
    n_starts = 0;
    pulse_go();
    run_to_idle(3000);
    check("s2_cfg_done", 32'(cfg_done), 1);
    check("s2_starts", 32'(n_starts), 12);
    check("s2_sb_empty", 32'(exp_q.size()), 0);

    // Entry 5 NACKs every attempt.
    nack_plan = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) push_exp(i);
    push_exp(5);
    push_exp(5);
    n_starts = 0;
    pulse_go();
    run_to_idle(3000);
    check("s3_cfg_fail", 32'(cfg_fail), 1);
    check("s3_cfg_done", 32'(cfg_done), 0);
    check("s3_index", 32'(index), 5);
    repeat (300) tick();
    check("s3_starts", 32'(n_starts), 8);
    check("s3_sb_empty", 32'(exp_q.size()), 0);
    nack_plan.delete();

    // Restart from FAIL; go while busy and go coincident with done.
    for (int i = 0; i < 10; i++) push_exp(i);
    pulse_go();
    check("s4_fail_cleared", 32'(cfg_fail), 0);
    for (int n = 0; n < 10 && eng_cnt == 0; n++) tick();
    repeat (3) begin
      repeat (20) tick();
      pulse_go();
    end
    check("s4_wait_index", 32'(index), 0);
    wait_eng_done();
    go = 1'b1;
    tick();
    go = 1'b0;
    check("s4_done_processed", 32'(index), 1);
    check("s4_still_busy", 32'(busy), 1);
    run_to_idle(3000);
    check("s4_cfg_done", 32'(cfg_done), 1);
    check("s4_sb_empty", 32'(exp_q.size()), 0);

    // go after DONE, then reset while waiting on entry 4.
    for (int i = 0; i < 10; i++) push_exp(i);
    n_starts = 0;
    pulse_go();
    check("s5_done_cleared", 32'(cfg_done), 0);
    check("s5_busy", 32'(busy), 1);
    check("s5_no_early_start", 32'(i2c_start), 0);
    tick();
    check("s5_start_lat2", 32'(i2c_start), 1);
    for (int n = 0; n < 1000 && n_starts < 5; n++) tick();
    check("s5_reached_entry4", 32'(n_starts), 5);
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_outputs("s5_rst");
    exp_q.delete();
    gap_pending = 1'b0;

    // Stray done while idle, then stray done during a gap.
    tb_done = 1'b1;
    tick();
    tb_done = 1'b0;
    repeat (3) tick();
    check("s6_idle_busy", 32'(busy), 0);
    check("s6_idle_index", 32'(index), 0);
    check("s6_idle_flags", 32'({cfg_done, cfg_fail}), 0);
    for (int i = 0; i < 10; i++) push_exp(i);
    pulse_go();
    check("s6_restart_index", 32'(index), 0);
    wait_eng_done();
    repeat (2) tick();
    tb_done = 1'b1;
    tick();
    tb_done = 1'b0;
    check("s6_gap_index", 32'(index), 1);
    check("s6_gap_busy", 32'(busy), 1);
    run_to_idle(3000);
    check("s6_cfg_done", 32'(cfg_done), 1);
    check("s6_index", 32'(index), 9);
    check("s6_sb_empty", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
